// File: rtl/instr_sequencer_if.sv
// CPU instruction handshake bundle between the sequencer and the CPU core.
//   cpu_in/cpu_load/cpu_s : instruction word, IR load strobe and start strobe (sequencer -> CPU)
//   cpu_w/cpu_out/cpu_N/V/Z: wait flag, datapath result and status flags (CPU -> sequencer)
interface instr_sequencer_if;
  logic [15:0] cpu_in;
  logic        cpu_load;
  logic        cpu_s;
  logic        cpu_w;
  logic [15:0] cpu_out;
  logic        cpu_N;
  logic        cpu_V;
  logic        cpu_Z;

  modport master (
    output cpu_in, cpu_load, cpu_s,
    input  cpu_w, cpu_out, cpu_N, cpu_V, cpu_Z
  );

  modport slave (
    input  cpu_in, cpu_load, cpu_s,
    output cpu_w, cpu_out, cpu_N, cpu_V, cpu_Z
  );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: holds a small program and issues it to the CPU core one
// instruction at a time (load, start, wait busy, wait idle, capture result).
//   clk, reset            : clock, synchronous active-high reset
//   prog_we/addr/data     : program memory write port (ignored while busy)
//   count, start          : run length (0..DEPTH) and one-cycle run request
//   cpu                   : handshake to the CPU core (master side)
//   result, flags         : last captured datapath_out and {N,V,Z}
//   result_valid          : one-cycle pulse per captured instruction
//   pc, busy, done, error : issue index, run in progress, run finished, timeout abort
module instr_sequencer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [15:0]       prog_data,
  input  logic [AW:0]       count,
  input  logic              start,
  instr_sequencer_if.master cpu,
  output logic [15:0]       result,
  output logic [2:0]        flags,
  output logic              result_valid,
  output logic [AW-1:0]     pc,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned DW = 16;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_CAPTURE, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   pc_d;
  logic [DW-1:0]   cpu_in_d, result_d;
  logic [2:0]      flags_d;
  logic            load_d, s_d, rv_d, busy_d, done_d, error_d;
  logic            timer_hit;
  logic [DW-1:0]   mem [DEPTH];

  // Program memory: no reset, writes only while idle or done.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) mem[prog_addr] <= prog_data;
  end

  // The wait states abort when the increment would land on TIMEOUT.
  assign timer_hit = (timer_q == TW'(TIMEOUT - 1));

  // Next state and next registered outputs; strobes are registered on state entry
  // so cpu_load is high exactly while in LOAD and cpu_s exactly while in START.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    count_d  = count_q;
    pc_d     = pc;
    cpu_in_d = cpu.cpu_in;
    result_d = result;
    flags_d  = flags;
    load_d   = 1'b0;
    s_d      = 1'b0;
    rv_d     = 1'b0;
    busy_d   = busy;
    done_d   = done;
    error_d  = error;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          if (count == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            count_d  = count;
            pc_d     = '0;
            busy_d   = 1'b1;
            state_d  = S_LOAD;
            load_d   = 1'b1;
            cpu_in_d = mem[AW'(0)];
          end
        end
      end
      S_LOAD: begin
        state_d = S_START;
        s_d     = 1'b1;
        timer_d = '0;
      end
      S_START: begin
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!cpu.cpu_w) begin
          state_d = S_WAIT_DONE;
          timer_d = '0;
        end else if (timer_hit) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (cpu.cpu_w) begin
          state_d  = S_CAPTURE;
          rv_d     = 1'b1;
          result_d = cpu.cpu_out;
          flags_d  = {cpu.cpu_N, cpu.cpu_V, cpu.cpu_Z};
        end else if (timer_hit) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_CAPTURE: begin
        // count_q >= 1 here, so the subtraction cannot underflow.
        if ((AW + 1)'(pc) == count_q - (AW + 1)'(1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          pc_d     = pc + AW'(1);
          state_d  = S_LOAD;
          load_d   = 1'b1;
          cpu_in_d = mem[pc + AW'(1)];
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      count_q      <= '0;
      pc           <= '0;
      cpu.cpu_in   <= '0;
      cpu.cpu_load <= 1'b0;
      cpu.cpu_s    <= 1'b0;
      result       <= '0;
      flags        <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      count_q      <= count_d;
      pc           <= pc_d;
      cpu.cpu_in   <= cpu_in_d;
      cpu.cpu_load <= load_d;
      cpu.cpu_s    <= s_d;
      result       <= result_d;
      flags        <= flags_d;
      result_valid <= rv_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer with a small behavioural CPU core model.
`timescale 1ns/1ps
module tb_instr_sequencer;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned AW      = 4;
  localparam int unsigned TIMEOUT = 255;

  typedef struct packed {
    logic [15:0] res;
    logic [2:0]  fl;
    logic [3:0]  pc;
  } exp_t;

  typedef struct packed {
    logic       err;
    logic [3:0] pc;
  } done_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [15:0]   prog_data = '0;
  logic [AW:0]   count = '0;
  logic          start = 1'b0;
  logic [15:0]   result;
  logic [2:0]    flags;
  logic          result_valid;
  logic [AW-1:0] pc;
  logic          busy, done, error;

  instr_sequencer_if cif();

  instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .count(count), .start(start), .cpu(cif),
    .result(result), .flags(flags), .result_valid(result_valid), .pc(pc),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  exp_t  exp_q[$];
  done_t done_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
  endtask

  // CPU core model: drops w one cycle after sampling s, raises it k cycles later.
  int          k = 2;
  logic        hang = 1'b0;
  logic        run;
  int          cnt;
  logic [15:0] ir, mv;
  logic [15:0] regs [8];

  always @(posedge clk) begin
    if (reset) begin
      cif.cpu_w   <= 1'b1;
      cif.cpu_out <= '0;
      cif.cpu_N   <= 1'b0;
      cif.cpu_V   <= 1'b0;
      cif.cpu_Z   <= 1'b0;
      run <= 1'b0;
      cnt <= 0;
      ir  <= '0;
    end else begin
      if (cif.cpu_load) ir <= cif.cpu_in;
      if (!run) begin
        if (cif.cpu_s) begin
          run <= 1'b1;
          cnt <= 0;
        end
      end else begin
        cnt <= cnt + 1;
        if (cnt == 0) cif.cpu_w <= 1'b0;
        else if (!hang && cnt == k) begin
          cif.cpu_w <= 1'b1;
          run <= 1'b0;
          if (ir[15:11] == 5'b11010) begin
            mv = {{8{ir[7]}}, ir[7:0]};
            regs[ir[10:8]] <= mv;
          end else if (ir[15:11] == 5'b10100) begin
            mv = regs[ir[10:8]] + regs[ir[2:0]];
            regs[ir[7:5]] <= mv;
          end else begin
            mv = '0;
          end
          cif.cpu_out <= mv;
        end
      end
    end
  end

  // Monitor: strobe hygiene counters plus scoreboard pops on result_valid / done rise.
  int   cyc = 0, load_cyc = 0, wfall_cyc = 0;
  int   n_load = 0, n_s = 0, n_both = 0, n_load_wide = 0, n_s_wide = 0;
  logic load_prev = 1'b0, s_prev = 1'b0, w_prev = 1'b1, done_prev = 1'b0;
  exp_t  e;
  done_t d;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (cif.cpu_load && cif.cpu_s) n_both++;
      if (cif.cpu_load && load_prev) n_load_wide++;
      if (cif.cpu_s && s_prev) n_s_wide++;
      if (cif.cpu_load && !load_prev) begin
        n_load++;
        load_cyc = cyc;
      end
      if (cif.cpu_s && !s_prev) n_s++;
      if (!cif.cpu_w && w_prev) wfall_cyc = cyc;
      if (result_valid) begin
        chk("rv_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("result", 32'(result), 32'(e.res));
          chk("flags", 32'(flags), 32'(e.fl));
          chk("capture_pc", 32'(pc), 32'(e.pc));
          chk("latency", 32'(cyc - load_cyc), 32'(4 + k));
        end
      end
      if (done && !done_prev) begin
        chk("done_expected", 32'(done_q.size() != 0), 1);
        if (done_q.size() != 0) begin
          d = done_q.pop_front();
          chk("done_error", 32'(error), 32'(d.err));
          chk("done_pc", 32'(pc), 32'(d.pc));
          chk("done_busy", 32'(busy), 0);
          if (d.err) chk("timeout_cycles", 32'(cyc - wfall_cyc), 32'(TIMEOUT + 1));
        end
      end
    end
    load_prev = cif.cpu_load;
    s_prev    = cif.cpu_s;
    w_prev    = cif.cpu_w;
    done_prev = done;
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cpu_in"}, 32'(cif.cpu_in), 0);
    chk({tag, "_cpu_load"}, 32'(cif.cpu_load), 0);
    chk({tag, "_cpu_s"}, 32'(cif.cpu_s), 0);
    chk({tag, "_result"}, 32'(result), 0);
    chk({tag, "_flags"}, 32'(flags), 0);
    chk({tag, "_result_valid"}, 32'(result_valid), 0);
    chk({tag, "_pc"}, 32'(pc), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
  endtask

  task automatic prog(input int a, input logic [15:0] v);
    prog_we   = 1'b1;
    prog_addr = AW'(a);
    prog_data = v;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  task automatic run_prog(input int c);
    count = (AW + 1)'(c);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("done_within_bound", 32'(done), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic push_exp(input logic [15:0] r, input int p);
    exp_q.push_back('{res: r, fl: 3'b000, pc: 4'(p)});
  endtask

  int nl, ns;
  logic found;
  logic [15:0] run6 [6];

  initial begin
    run6[0] = 16'h0007; run6[1] = 16'h0002; run6[2] = 16'h0009;
    run6[3] = 16'h0003; run6[4] = 16'h0004; run6[5] = 16'h0005;

    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;

    // count = 0 completes on the next cycle with no strobes
    nl = n_load; ns = n_s;
    done_q.push_back('{err: 1'b0, pc: 4'd0});
    run_prog(0);
    chk("cnt0_done", 32'(done), 1);
    chk("cnt0_error", 32'(error), 0);
    chk("cnt0_busy", 32'(busy), 0);
    repeat (4) @(negedge clk);
    chk("cnt0_no_load", 32'(n_load - nl), 0);
    chk("cnt0_no_s", 32'(n_s - ns), 0);

    prog(0, 16'hD007);
    prog(1, 16'hD102);
    prog(2, 16'hA140);
    prog(3, 16'hD003);
    prog(4, 16'hD204);
    prog(5, 16'hD105);

    // three-instruction program; a write to word 5 while busy must be dropped
    k = 2;
    nl = n_load; ns = n_s;
    for (int i = 0; i < 3; i++) push_exp(run6[i], i);
    done_q.push_back('{err: 1'b0, pc: 4'd2});
    run_prog(3);
    chk("run1_busy", 32'(busy), 1);
    prog(5, 16'hD17F);
    wait_done(200);
    chk("run1_result", 32'(result), 32'h0009);
    chk("run1_flags", 32'(flags), 0);
    chk("run1_error", 32'(error), 0);
    chk("run1_loads", 32'(n_load - nl), 3);
    chk("run1_starts", 32'(n_s - ns), 3);

    // six words: word 5 must still hold its pre-run value
    k = 3;
    for (int i = 0; i < 6; i++) push_exp(run6[i], i);
    done_q.push_back('{err: 1'b0, pc: 4'd5});
    run_prog(6);
    wait_done(300);

    // full depth run, pc must reach DEPTH-1 without wrapping
    for (int i = 6; i < 16; i++) prog(i, {8'hD3, 8'(i)});
    k = 1;
    for (int i = 0; i < 6; i++) push_exp(run6[i], i);
    for (int i = 6; i < 16; i++) push_exp(16'(i), i);
    done_q.push_back('{err: 1'b0, pc: 4'd15});
    run_prog(16);
    wait_done(600);

    // CPU that never returns to wait: timeout abort at pc 0
    hang = 1'b1;
    done_q.push_back('{err: 1'b1, pc: 4'd0});
    run_prog(2);
    wait_done(TIMEOUT + 50);
    chk("to_error", 32'(error), 1);
    chk("to_result_kept", 32'(result), 32'h000F);
    chk("to_flags_kept", 32'(flags), 0);

    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_after_timeout");
    reset = 1'b0;
    hang  = 1'b0;

    // reset during WAIT_DONE of instruction 1
    k = 20;
    push_exp(16'h0007, 0);
    run_prog(3);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (pc == AW'(1) && !cif.cpu_w) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("midrun_reached", 32'(found), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_mid_run");
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_idle_busy", 32'(busy), 0);

    k = 2;
    for (int i = 0; i < 3; i++) push_exp(run6[i], i);
    done_q.push_back('{err: 1'b0, pc: 4'd2});
    run_prog(3);
    wait_done(200);

    repeat (3) @(negedge clk);
    chk("exp_queue_drained", 32'(exp_q.size()), 0);
    chk("done_queue_drained", 32'(done_q.size()), 0);
    chk("load_s_overlap", 32'(n_both), 0);
    chk("load_width", 32'(n_load_wide), 0);
    chk("s_width", 32'(n_s_wide), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Initiator side of the CPU instruction handshake: the CPU core waits for `load`/`in`/`s` and answers with `w`, `out` and `N`/`V`/`Z`.
- This block stores a small program in an internal register-file memory and issues it one instruction at a time:
  - drives the instruction word and pulses load, then pulses start;
  - waits for the core to go busy and return to wait;
  - captures the datapath result and flags after each instruction.
- Sits between the lab-board/testbench front end and the CPU top. Lets a whole program run from one start pulse.

Parameters:
- DEPTH, 16, number of 16-bit program words (power of two)
- AW, 4, program address width (log2 DEPTH)
- TIMEOUT, 255, max cycles spent in any wait state before abort

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- prog_we  input  1  program write enable (honoured only when busy=0)
- prog_addr  input  AW  program write address
- prog_data  input  16  program write data
- count  input  AW+1  number of instructions to run (0..DEPTH), sampled on start
- start  input  1  one-cycle run request (ignored when busy=1)
- cpu_w  input  1  CPU wait/idle flag
- cpu_out  input  16  CPU datapath_out
- cpu_N, cpu_V, cpu_Z  input  1 each  CPU status flags
- cpu_in  output  16  instruction word to CPU
- cpu_load  output  1  CPU instruction-register load strobe
- cpu_s  output  1  CPU start strobe
- result  output  16  last captured cpu_out
- flags  output  3  last captured {N,V,Z}
- result_valid  output  1  one-cycle pulse per captured instruction
- pc  output  AW  index of the instruction being issued
- busy  output  1  high from the cycle after start until DONE
- done  output  1  high in DONE; held until next start or reset
- error  output  1  timeout abort indicator; held with done

Behaviour:
- Reset values:
  - outputs: cpu_in=0, cpu_load=0, cpu_s=0, result=0, flags=0, result_valid=0, pc=0, busy=0, done=0, error=0.
  - state=IDLE, timer=0.
  - Program memory contents are not reset.
- Memory: prog_we and busy=0 writes prog_data to mem[prog_addr] at the clock edge. Writes while busy=1 are dropped.
- IDLE:
  - start=1 with count=0 → DONE; done=1, error=0.
  - start=1 with count>0 → latch count, pc=0, busy=1, go LOAD.
- LOAD: cpu_in=mem[pc] registered, cpu_load=1 for exactly one cycle → START. cpu_in then holds its value until the next LOAD.
- START: cpu_s=1 for exactly one cycle, timer=0 → WAIT_BUSY.
- WAIT_BUSY:
  - cpu_w=0 → WAIT_DONE, timer=0.
  - else timer++.
- WAIT_DONE:
  - cpu_w=1 → CAPTURE.
  - else timer++.
- CAPTURE:
  - result<=cpu_out, flags<={cpu_N,cpu_V,cpu_Z}, result_valid=1 for one cycle.
  - pc==count-1 → DONE.
  - otherwise pc<=pc+1 → LOAD.
- DONE:
  - busy=0, done=1.
  - start=1 → clear done/error and behave as in IDLE (a new run or count=0 completes).
- Timeout: in WAIT_BUSY or WAIT_DONE, timer reaching TIMEOUT → DONE with error=1. Result and flags keep their last captured value, and pc keeps the failing index.
- Per-instruction latency for a CPU that drops w one cycle after s and raises it K cycles later: 3+K+1 cycles from LOAD entry to result_valid.
- cpu_load and cpu_s are never high in the same cycle.
- count=DEPTH runs all words; pc never wraps within a run.
- A reset asserted mid-run aborts immediately to the reset values; it never emits cpu_s.
- start during busy has no effect.

Test Plan:
- Program mem[0..2]=0xD007 (MOV R0,#7), 0xD102 (MOV R1,#2), 0xA140 (ADD R2,R1,R0) with the real CPU attached; count=3, start → three result_valid pulses, final result=0x0009, flags=3'b000, done=1, error=0.
- count=0, start → done=1 on the next cycle; no cpu_load or cpu_s pulse ever seen.
- CPU model that holds cpu_w=0 forever after s → error=1 and done=1 exactly TIMEOUT cycles after entering WAIT_DONE; pc=0.
- prog_we to address 5 while busy=1 → mem[5] unchanged (read back by a later run with count=6).
- reset pulsed during WAIT_DONE of instruction 1 → next cycle all outputs are at their reset values, state is IDLE, and the next start runs from pc=0.
- Check every cycle of the count=3 run: cpu_load and cpu_s are never simultaneous, and each is high for exactly one cycle per instruction.
